// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: power-on and lock-supervision sequencer for the system PLL.
// Pulses pll_reset and waits for lock, retrying on timeout up to MAX_RETRY times.
// Once lock has been stable, it releases N_RST staggered domain resets.
// Loss of lock re-asserts every reset and restarts the whole sequence.
// Ports:
//   refclk       in   reference clock, the only clock
//   reset        in   synchronous, active-high
//   pll_extlock  in   PLL lock indicator, asynchronous to refclk
//   pll_reset    out  reset to the PLL
//   sys_rst      out  active-high domain resets, bit 0 released first
//   ready        out  all domain resets released and lock held
//   lock_lost    out  one-cycle pulse on loss of lock in RELEASE/RUN
//   retry_count  out  saturating count of lock timeouts since reset
//   fail         out  sticky, retries exhausted
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 240,
    parameter int unsigned LOCK_TIMEOUT       = 24000,
    parameter int unsigned LOCK_STABLE_CYCLES = 2400,
    parameter int unsigned N_RST              = 4,
    parameter int unsigned RST_STAGGER        = 16,
    parameter int unsigned MAX_RETRY          = 7
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             pll_extlock,
    output logic             pll_reset,
    output logic [N_RST-1:0] sys_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic [2:0]       retry_count,
    output logic             fail
);

    localparam int unsigned MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD  = (PLL_RST_CYCLES > RST_STAGGER) ? PLL_RST_CYCLES : RST_STAGGER;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(N_RST + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_sync1;
    logic               r_lock_s;
    logic               r_pll_reset;
    logic [N_RST-1:0]   r_sys_rst;
    logic               r_ready;
    logic               r_lock_lost;
    logic [2:0]         r_retry_count;
    logic               r_fail;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_pll_reset_nxt;
    logic [N_RST-1:0]   w_sys_rst_nxt;
    logic               w_ready_nxt;
    logic               w_lock_lost_nxt;
    logic [2:0]         w_retry_count_nxt;
    logic               w_fail_nxt;

    // State, counters, synchroniser and output registers
    always_ff @(posedge refclk) begin
        if (reset) begin
            r_state       <= S_PLL_RST;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_sync1       <= 1'b0;
            r_lock_s      <= 1'b0;
            r_pll_reset   <= 1'b1;
            r_sys_rst     <= {N_RST{1'b1}};
            r_ready       <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_retry_count <= 3'd0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_sync1       <= pll_extlock;
            r_lock_s      <= r_sync1;
            r_pll_reset   <= w_pll_reset_nxt;
            r_sys_rst     <= w_sys_rst_nxt;
            r_ready       <= w_ready_nxt;
            r_lock_lost   <= w_lock_lost_nxt;
            r_retry_count <= w_retry_count_nxt;
            r_fail        <= w_fail_nxt;
        end
    end

    // Next state and next output values; the shared counter clears on every transition
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt + CNT_W'(1);
        w_idx_nxt         = r_idx;
        w_pll_reset_nxt   = r_pll_reset;
        w_sys_rst_nxt     = r_sys_rst;
        w_ready_nxt       = r_ready;
        w_lock_lost_nxt   = 1'b0;
        w_retry_count_nxt = r_retry_count;
        w_fail_nxt        = r_fail;

        case (r_state)
            S_PLL_RST: begin
                w_pll_reset_nxt = 1'b1;
                if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    w_state_nxt     = S_WAIT_LOCK;
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b0;
                end
            end

            // Lock wins over a timeout landing on the same cycle
            S_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b1;
                    if (32'(r_retry_count) >= MAX_RETRY) begin
                        w_state_nxt   = S_FAIL;
                        w_fail_nxt    = 1'b1;
                        w_sys_rst_nxt = {N_RST{1'b1}};
                        w_ready_nxt   = 1'b0;
                    end else begin
                        w_state_nxt       = S_PLL_RST;
                        w_retry_count_nxt = (r_retry_count == 3'd7) ? r_retry_count
                                                                    : r_retry_count + 3'd1;
                    end
                end
            end

            // A single low sample restarts the wait without counting as a retry
            S_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            S_RELEASE: begin
                if (!r_lock_s) begin
                    w_state_nxt     = S_PLL_RST;
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b1;
                    w_sys_rst_nxt   = {N_RST{1'b1}};
                    w_ready_nxt     = 1'b0;
                    w_lock_lost_nxt = 1'b1;
                end else if (r_cnt == CNT_W'(RST_STAGGER - 1)) begin
                    w_cnt_nxt     = '0;
                    w_sys_rst_nxt = r_sys_rst & ~(N_RST'(1) << r_idx);
                    w_idx_nxt     = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(N_RST - 1)) begin
                        w_state_nxt = S_RUN;
                        w_ready_nxt = 1'b1;
                    end
                end
            end

            S_RUN: begin
                w_cnt_nxt = '0;
                if (!r_lock_s) begin
                    w_state_nxt     = S_PLL_RST;
                    w_pll_reset_nxt = 1'b1;
                    w_sys_rst_nxt   = {N_RST{1'b1}};
                    w_ready_nxt     = 1'b0;
                    w_lock_lost_nxt = 1'b1;
                end
            end

            // Terminal until reset; lock is ignored
            S_FAIL: begin
                w_cnt_nxt       = '0;
                w_pll_reset_nxt = 1'b1;
                w_sys_rst_nxt   = {N_RST{1'b1}};
                w_ready_nxt     = 1'b0;
                w_fail_nxt      = 1'b1;
            end

            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign pll_reset   = r_pll_reset;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry_count;
    assign fail        = r_fail;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: table-driven nominal/lock-loss vectors,
// hand sequences for retry, exhaustion, glitch and mid-release reset, and
// random lock patterns checked cycle by cycle against a phase/timestamp model.
module tb_pll_lock_sequencer;

    localparam int unsigned PRC  = 4;
    localparam int unsigned LTO  = 20;
    localparam int unsigned LSC  = 8;
    localparam int unsigned STG  = 3;
    localparam int unsigned NR   = 4;
    localparam int unsigned MAXR = 2;

    logic          refclk;
    logic          reset;
    logic          pll_extlock;
    logic          pll_reset;
    logic [NR-1:0] sys_rst;
    logic          ready;
    logic          lock_lost;
    logic [2:0]    retry_count;
    logic          fail;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_TIMEOUT       (LTO),
        .LOCK_STABLE_CYCLES (LSC),
        .N_RST              (NR),
        .RST_STAGGER        (STG),
        .MAX_RETRY          (MAXR)
    ) dut (
        .refclk      (refclk),
        .reset       (reset),
        .pll_extlock (pll_extlock),
        .pll_reset   (pll_reset),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .retry_count (retry_count),
        .fail        (fail)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase plus time elapsed in it; outputs are pure functions of the phase.
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;
    int m_phase = P_RST;
    int m_el    = 0;
    int m_rel   = 0;
    int m_retry = 0;
    bit m_lost  = 0;
    bit m_hist[$];

    task automatic m_go(input int p);
        m_phase = p;
        m_el    = 0;
    endtask

    // Advance the model by one refclk edge with the inputs sampled at that edge
    task automatic model_step(input bit rst, input bit ext);
        bit ls;
        if (rst) begin
            m_phase = P_RST; m_el = 0; m_rel = 0; m_retry = 0; m_lost = 0;
            m_hist = {1'b0, 1'b0};
            return;
        end
        ls = m_hist.pop_front();   // lock seen by the sequencer = extlock two edges ago
        m_hist.push_back(ext);
        m_lost = 0;
        case (m_phase)
            P_RST:  if (m_el + 1 == PRC) m_go(P_WAIT); else m_el++;
            P_WAIT: begin
                if (ls) m_go(P_STAB);
                else if (m_el + 1 == LTO) begin
                    if (m_retry >= MAXR) m_go(P_FAIL);
                    else begin
                        m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                        m_go(P_RST);
                    end
                end else m_el++;
            end
            P_STAB: begin
                if (!ls) m_go(P_WAIT);
                else if (m_el + 1 == LSC) begin m_go(P_REL); m_rel = 0; end
                else m_el++;
            end
            P_REL: begin
                if (!ls) begin m_lost = 1; m_go(P_RST); end
                else begin
                    m_el++;
                    if (m_el % STG == 0) m_rel++;
                    if (m_rel == NR) m_go(P_RUN);
                end
            end
            P_RUN:  if (!ls) begin m_lost = 1; m_go(P_RST); end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] m_sysrst();
        logic [31:0] all = (32'd1 << NR) - 1;
        if (m_phase == P_RUN) return 32'd0;
        if (m_phase == P_REL) return all & ~((32'd1 << m_rel) - 1);
        return all;
    endfunction

    task automatic compare_model();
        chk("model.pll_reset",   32'(pll_reset),   32'((m_phase == P_RST) || (m_phase == P_FAIL)));
        chk("model.sys_rst",     32'(sys_rst),     m_sysrst());
        chk("model.ready",       32'(ready),       32'(m_phase == P_RUN));
        chk("model.lock_lost",   32'(lock_lost),   32'(m_lost));
        chk("model.retry_count", 32'(retry_count), 32'(m_retry));
        chk("model.fail",        32'(fail),        32'(m_phase == P_FAIL));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit rst, input bit ext);
        @(negedge refclk);
        reset       = rst;
        pll_extlock = ext;
        model_step(rst, ext);
        @(posedge refclk);
        #1;
        compare_model();
    endtask

    task automatic run(input bit rst, input bit ext, input int n);
        for (int k = 0; k < n; k++) step(rst, ext);
    endtask

    task automatic expect_out(input string tag, input bit pr, input logic [3:0] sr, input bit rdy,
                              input bit ll, input logic [2:0] rc, input bit fl);
        chk({tag, ".pll_reset"},   32'(pll_reset),   32'(pr));
        chk({tag, ".sys_rst"},     32'(sys_rst),     32'(sr));
        chk({tag, ".ready"},       32'(ready),       32'(rdy));
        chk({tag, ".lock_lost"},   32'(lock_lost),   32'(ll));
        chk({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
        chk({tag, ".fail"},        32'(fail),        32'(fl));
    endtask

    typedef struct {
        bit         rst;
        bit         ext;
        int         hold;
        bit         pr;
        logic [3:0] sr;
        bit         rdy;
        bit         ll;
        logic [2:0] rc;
        bit         fl;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit ext, input int hold, input bit pr,
                                input logic [3:0] sr, input bit rdy, input bit ll,
                                input logic [2:0] rc, input bit fl);
        vec_t v;
        v.rst = rst; v.ext = ext; v.hold = hold; v.pr = pr; v.sr = sr;
        v.rdy = rdy; v.ll = ll; v.rc = rc; v.fl = fl;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        reset       = 1'b1;
        pll_extlock = 1'b0;
        model_step(1'b1, 1'b0);

        // Nominal start (E = edge 11 samples the lock rise) followed by loss of lock in RUN
        tbl.push_back(mk(1, 0,  2, 1, 4'hF, 0, 0, 0, 0));  // reset values
        tbl.push_back(mk(0, 0,  3, 1, 4'hF, 0, 0, 0, 0));  // pll_reset still high after 3 edges
        tbl.push_back(mk(0, 0,  1, 0, 4'hF, 0, 0, 0, 0));  // low after the 4th
        tbl.push_back(mk(0, 0,  6, 0, 4'hF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 13, 0, 4'hF, 0, 0, 0, 0));  // E+12
        tbl.push_back(mk(0, 1,  1, 0, 4'hE, 0, 0, 0, 0));  // E+13
        tbl.push_back(mk(0, 1,  2, 0, 4'hE, 0, 0, 0, 0));  // E+15
        tbl.push_back(mk(0, 1,  1, 0, 4'hC, 0, 0, 0, 0));  // E+16
        tbl.push_back(mk(0, 1,  3, 0, 4'h8, 0, 0, 0, 0));  // E+19
        tbl.push_back(mk(0, 1,  2, 0, 4'h8, 0, 0, 0, 0));  // E+21
        tbl.push_back(mk(0, 1,  1, 0, 4'h0, 1, 0, 0, 0));  // E+22 ready
        tbl.push_back(mk(0, 1,  5, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  2, 0, 4'h0, 1, 0, 0, 0));  // lock dropped, not yet seen
        tbl.push_back(mk(0, 0,  1, 1, 4'hF, 0, 1, 0, 0));  // 3rd edge: resets back, pulse
        tbl.push_back(mk(0, 0,  1, 1, 4'hF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  2, 1, 4'hF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 4'hF, 0, 0, 0, 0));  // pll_reset high for 4 cycles
        tbl.push_back(mk(0, 1, 22, 0, 4'h8, 0, 0, 0, 0));  // sequence repeats
        tbl.push_back(mk(0, 1,  1, 0, 4'h0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            run(tbl[i].rst, tbl[i].ext, tbl[i].hold);
            expect_out($sformatf("vec%0d", i), tbl[i].pr, tbl[i].sr, tbl[i].rdy,
                       tbl[i].ll, tbl[i].rc, tbl[i].fl);
        end

        // Timeout retry: lock arrives on the third attempt
        run(1, 0, 2);
        run(0, 0, 4);  expect_out("retry.e4",  0, 4'hF, 0, 0, 0, 0);
        run(0, 0, 19); expect_out("retry.e23", 0, 4'hF, 0, 0, 0, 0);
        run(0, 0, 1);  expect_out("retry.e24", 1, 4'hF, 0, 0, 1, 0);
        run(0, 0, 3);  expect_out("retry.e27", 1, 4'hF, 0, 0, 1, 0);
        run(0, 0, 1);  expect_out("retry.e28", 0, 4'hF, 0, 0, 1, 0);
        run(0, 0, 19); expect_out("retry.e47", 0, 4'hF, 0, 0, 1, 0);
        run(0, 0, 1);  expect_out("retry.e48", 1, 4'hF, 0, 0, 2, 0);
        run(0, 0, 3);  expect_out("retry.e51", 1, 4'hF, 0, 0, 2, 0);
        run(0, 0, 1);  expect_out("retry.e52", 0, 4'hF, 0, 0, 2, 0);
        run(0, 1, 40); expect_out("retry.up",  0, 4'h0, 1, 0, 2, 0);

        // Retry exhaustion: third timeout is terminal, lock is then ignored
        run(1, 0, 2);
        run(0, 0, 71); expect_out("exh.e71",   0, 4'hF, 0, 0, 2, 0);
        run(0, 0, 1);  expect_out("exh.e72",   1, 4'hF, 0, 0, 2, 1);
        run(0, 1, 50); expect_out("exh.lock",  1, 4'hF, 0, 0, 2, 1);
        run(0, 0, 30); expect_out("exh.hold",  1, 4'hF, 0, 0, 2, 1);

        // Glitch during STABLE restarts the stability window
        run(1, 0, 2);
        run(0, 0, 6);
        run(0, 1, 5);
        run(0, 0, 1);
        run(0, 1, 13); expect_out("glitch.e25", 0, 4'hF, 0, 0, 0, 0);
        run(0, 1, 1);  expect_out("glitch.e26", 0, 4'hE, 0, 0, 0, 0);

        // Reset asserted mid-RELEASE
        run(1, 0, 2);
        run(0, 1, 15); expect_out("midrel.e15", 0, 4'hF, 0, 0, 0, 0);
        run(0, 1, 1);  expect_out("midrel.e16", 0, 4'hE, 0, 0, 0, 0);
        run(0, 1, 1);
        run(1, 1, 1);  expect_out("midrel.rst", 1, 4'hF, 0, 0, 0, 0);

        // Random lock patterns with occasional resets
        for (int ep = 0; ep < 6; ep++) begin
            step(1'b1, 1'b0);
            for (int c = 0; c < 2500; ) begin
                int len;
                bit v;
                len = int'($urandom_range(1, 60));
                v   = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < len; k++) step($urandom_range(0, 999) == 0, v);
                c += len;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
